// File: rtl/pow_arb_pkg.sv
// pow_arb_pkg: shared state encoding, default widths and a constant clog2
// helper for the pow_arbiter slice (pow_arbiter, rr_picker).
package pow_arb_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first asserted
// request found when searching upward from i_ptr, wrapping past N-1 to 0.
module rr_picker
  import pow_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  // One spare bit so ptr + offset can exceed N-1 before the wrap.
  logic [IDW:0] w_pos;

  // Walk the N candidate positions in priority order and keep the first hit.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_pos >= (IDW+1)'(N)) begin
        w_pos = w_pos - (IDW+1)'(N);
      end
      if (!o_valid && i_req[w_pos[IDW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IDW-1:0];
      end
    end
    if (o_valid) begin
      o_grant = {{(N-1){1'b0}}, 1'b1} << o_idx;
    end
  end

endmodule

// File: rtl/pow_arbiter.sv
// pow_arbiter: shares one a^b mod 2^W engine among N requesters. Requests are
// granted round-robin, sequenced through the engine start/done handshake and
// returned on a single tagged response channel.
// Optional feature: define POW_ARB_TIMEOUT_EN to enable the engine watchdog
// (eng_reset pulse plus resp_err on expiry). Without it the block waits on
// the engine indefinitely and eng_reset/resp_err are tied low.
module pow_arbiter
  import pow_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*W-1:0]        req_a,
  input  logic [N*W-1:0]        req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [clog2(N)-1:0]   resp_id,
  output logic [W-1:0]          resp_data,
  output logic                  resp_err,
  output logic                  eng_start,
  output logic [W-1:0]          eng_a,
  output logic [W-1:0]          eng_b,
  input  logic [W-1:0]          eng_result,
  input  logic                  eng_done,
  output logic                  eng_reset,
  output logic                  busy
);

  localparam int IDW = clog2(N);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_resp_data;

  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gidx;
  logic           w_gvalid;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           w_expire;

  rr_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  assign w_sel_a = req_a[w_gidx*W +: W];
  assign w_sel_b = req_b[w_gidx*W +: W];

`ifdef POW_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_resp_err;
  logic          w_waiting;

  assign w_waiting = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  // A done seen in WAIT_HI wins over an expiry landing in the same cycle.
  assign w_expire  = w_waiting && (r_wd_cnt == CW'(TIMEOUT)) &&
                     !((r_state == S_WAIT_HI) && eng_done);

  // Watchdog: cleared while issuing, counts each cycle spent waiting on the engine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (w_waiting && (r_wd_cnt != CW'(TIMEOUT))) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Error flag: cleared by a normal completion, set by a watchdog expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_err <= 1'b0;
    end else if ((r_state == S_WAIT_HI) && eng_done) begin
      r_resp_err <= 1'b0;
    end else if (w_expire) begin
      r_resp_err <= 1'b1;
    end
  end

  assign eng_reset = w_expire;
  assign resp_err  = r_resp_err;
`else
  assign w_expire  = 1'b0;
  assign eng_reset = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs derived from the current state.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    eng_start   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = w_grant;
        if (w_gvalid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start   = 1'b1;
        w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_expire) begin
          w_state_nxt = S_RESP;
        end else if (!eng_done) begin
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (eng_done || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand/tag latches, result capture and round-robin pointer update.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every datapath register is reset here; outputs read straight from them must be 0 under reset.
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gvalid) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_id <= w_gidx;
          end
        end
        S_WAIT_LO, S_WAIT_HI: begin
          if ((r_state == S_WAIT_HI) && eng_done) begin
            r_resp_data <= eng_result;
          end else if (w_expire) begin
            r_resp_data <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_ptr <= (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign eng_a     = r_a;
  assign eng_b     = r_b;
  assign resp_id   = r_id;
  assign resp_data = r_resp_data;

endmodule

// File: tb/tb_pow_arbiter.sv
// tb_pow_arbiter: randomized and directed stimulus for pow_arbiter, checked
// against a request-level reference model (round-robin pick by index search,
// power by repeated multiplication) and driving a behavioural engine model.
`timescale 1ns/1ps
module tb_pow_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic [W-1:0]   eng_result;
  logic           eng_done;
  logic           eng_reset;
  logic           busy;

  always #5 clk = ~clk;

  pow_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_result (eng_result),
    .eng_done   (eng_done),
    .eng_reset  (eng_reset),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int         eng_lat  = 3;
  bit         eng_hang = 1'b0;
  logic       eng_seen_start;
  logic       eng_running;
  int         eng_cnt;
  logic [W-1:0] eng_pend;

  function automatic logic [W-1:0] sqm_pow(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = 1;
    logic [W-1:0] x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r = r * x;
      x = x * x;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset || eng_reset) begin
      eng_done       <= 1'b1;
      eng_result     <= '0;
      eng_seen_start <= 1'b0;
      eng_running    <= 1'b0;
      eng_cnt        <= 0;
      eng_pend       <= '0;
    end else begin
      eng_seen_start <= eng_start;
      if (eng_seen_start) begin
        eng_done    <= 1'b0;
        eng_running <= 1'b1;
        eng_cnt     <= eng_lat;
        eng_pend    <= sqm_pow(eng_a, eng_b);
      end else if (eng_running && !eng_hang) begin
        if (eng_cnt <= 1) begin
          eng_done    <= 1'b1;
          eng_result  <= eng_pend;
          eng_running <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = 1;
    for (int unsigned i = 0; i < b; i++) r = r * a;
    return r;
  endfunction

  // Lowest requesting index at or above ptr, otherwise lowest overall.
  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
    for (int i = ptr; i < N; i++) if (v[i]) return i;
    for (int i = 0; i < ptr; i++) if (v[i]) return i;
    return -1;
  endfunction

  bit           m_busy = 0;
  int           m_ptr = 0;
  int           m_gid = 0;
  logic [W-1:0] m_a, m_b, m_exp;
  bit           m_start_due = 0;
  bit           m_resp_on = 0;
  bit           m_rise_pending = 0;
  logic         prev_done = 1'b1;

  int           cyc = 0;
  int           n_done = 0;
  int           grant_log[$];
  logic [W-1:0] last_data[N];
  logic         last_err;
  int           last_hs_cyc = 0;
  int           last_grant_cyc = 0;
  int           last_erst_cyc = 0;
  int           first_resp_cyc = -1;
  int           start_cnt = 0;
  int           rst_pulses = 0;
  logic [N-1:0] drop_mask = '0;
  bit           auto_drop = 1;
  bit           rand_mode = 0;
  bit           rand_new = 0;

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_start_due = 0; m_resp_on = 0;
    m_rise_pending = 0; prev_done = 1'b1; drop_mask = '0;
  endtask

  task automatic observe();
    int g;
    logic [N-1:0] exp_ready;
    cyc++;
    if (m_rise_pending) m_resp_on = 1;
    m_rise_pending = 0;
    g = m_busy ? -1 : ref_pick(req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_busy);
    check("eng_start", eng_start, m_start_due);
    if (eng_start) start_cnt++;
    if (m_start_due) begin
      check("eng_a", eng_a, m_a);
      check("eng_b", eng_b, m_b);
    end
    if (!eng_hang) begin
      check("resp_valid", resp_valid, m_resp_on);
      check("eng_reset", eng_reset, 1'b0);
    end
    if (eng_reset) begin
      rst_pulses++;
      last_erst_cyc = cyc;
    end
    if (resp_valid) begin
      if (first_resp_cyc < 0) first_resp_cyc = cyc;
      check("resp_id", resp_id, m_gid);
      check("resp_data", resp_data, eng_hang ? '0 : m_exp);
      check("resp_err", resp_err, eng_hang);
      if (resp_ready) begin
        m_busy = 0;
        m_ptr = (m_gid + 1) % N;
        m_resp_on = 0;
        n_done++;
        last_data[m_gid] = resp_data;
        last_err = resp_err;
        last_hs_cyc = cyc;
      end
    end
    m_start_due = 0;
    if (g >= 0) begin
      m_busy = 1;
      m_gid = g;
      m_a = req_a[g*W +: W];
      m_b = req_b[g*W +: W];
      m_exp = ref_pow(m_a, m_b);
      m_start_due = 1;
      grant_log.push_back(g);
      last_grant_cyc = cyc;
      first_resp_cyc = -1;
      if (auto_drop) drop_mask[g] = 1'b1;
    end
    if (eng_done && !prev_done && m_busy && !eng_hang) m_rise_pending = 1;
    prev_done = eng_done;
  endtask

  // One cycle: apply requester updates at the falling edge, sample 1ns later.
  task automatic step();
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && rand_new && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*W +: W] = $urandom;
          req_b[i*W +: W] = $urandom_range(40);
        end
      end
      resp_ready = ($urandom_range(9) < 7);
      eng_lat = $urandom_range(1, 6);
    end
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    check("completions", n_done, target);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".resp_valid"}, resp_valid, 0);
    check({tag, ".resp_id"},    resp_id,    0);
    check({tag, ".resp_data"},  resp_data,  0);
    check({tag, ".resp_err"},   resp_err,   0);
    check({tag, ".eng_start"},  eng_start,  0);
    check({tag, ".eng_a"},      eng_a,      0);
    check({tag, ".eng_b"},      eng_b,      0);
    check({tag, ".eng_reset"},  eng_reset,  0);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".req_ready"},  req_ready,  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int base;
    int gl;
    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    step();

    // Single request and arithmetic corner cases.
    resp_ready = 1'b1;
    start_cnt = 0;
    request(0, 3, 4);
    run_until(1, 200);
    check("single.data", last_data[0], 81);
    check("single.err", last_err, 0);
    check("single.start_cycles", start_cnt, 1);
    request(1, 7, 0);
    run_until(2, 200);
    check("zero_exp.data", last_data[1], 1);
    request(2, 32'h0001_0000, 2);
    run_until(3, 200);
    check("wrap.data", last_data[2], 0);
    request(3, 12, 5);
    run_until(4, 200);
    check("req3.data", last_data[3], 248832);

    // Round-robin with every requester held valid.
    auto_drop = 0;
    gl = grant_log.size();
    request(0, 3, 5);
    request(1, 2, 10);
    request(2, 5, 3);
    request(3, 9, 2);
    base = n_done;
    run_until(base + 5, 500);
    req_valid = '0;
    auto_drop = 1;
    for (int i = 0; i < 5; i++) begin
      if (gl + i < grant_log.size()) check($sformatf("rr.order%0d", i), grant_log[gl + i], i % N);
      else check($sformatf("rr.order%0d", i), 32'hFFFF_FFFF, i % N);
    end
    check("rr.id1_data", last_data[1], 1024);
    check("rr.id2_data", last_data[2], 125);

    // Backpressure: result held 20 cycles, then next grant right after release.
    resp_ready = 1'b0;
    base = n_done;
    request(2, 6, 7);
    k = 0;
    while (!resp_valid && k < 100) begin
      step();
      k++;
    end
    check("bp.resp_valid", resp_valid, 1);
    request(3, 11, 3);
    repeat (20) begin
      step();
      check("bp.hold_data", resp_data, 279936);
    end
    resp_ready = 1'b1;
    step();
    step();
    check("bp.next_grant_gap", last_grant_cyc - last_hs_cyc, 1);
    check("bp.next_grant_id", grant_log[grant_log.size() - 1], 3);
    run_until(base + 2, 200);
    check("bp.id3_data", last_data[3], 1331);

    // Reset while waiting for the engine result.
    eng_lat = 30;
    request(0, 9, 9);
    k = 0;
    while (eng_done && k < 50) begin
      step();
      k++;
    end
    check("mid.eng_busy", eng_done, 0);
    step();
    step();
    req_valid = '0;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    eng_lat = 3;
    base = n_done;
    request(2, 5, 3);
    run_until(base + 1, 200);
    check("postreset.data", last_data[2], 125);
    check("postreset.id", grant_log[grant_log.size() - 1], 2);

    // Randomized traffic with random backpressure and engine latency.
    rand_mode = 1;
    rand_new = 1;
    repeat (600) step();
    rand_new = 0;
    k = 0;
    while ((req_valid != '0 || m_busy) && k < 3000) begin
      step();
      k++;
    end
    rand_mode = 0;
    resp_ready = 1'b1;
    eng_lat = 3;
    step();
    check("drain.busy", busy, 0);

`ifdef POW_ARB_TIMEOUT_EN
    // Engine never finishes: watchdog must reset it and report an error.
    eng_hang = 1;
    rst_pulses = 0;
    resp_ready = 1'b0;
    base = n_done;
    request(0, 3, 3);
    k = 0;
    while (!resp_valid && k < 200) begin
      step();
      k++;
    end
    check("to.resp_valid", resp_valid, 1);
    check("to.pulses", rst_pulses, 1);
    check("to.latency", last_erst_cyc - last_grant_cyc, TO + 2);
    check("to.resp_after_reset", first_resp_cyc - last_erst_cyc, 1);
    resp_ready = 1'b1;
    step();
    eng_hang = 0;
    check("to.err", last_err, 1);
    check("to.data", last_data[0], 0);
    request(1, 4, 4);
    run_until(base + 2, 200);
    check("to.next_data", last_data[1], 256);
    check("to.next_err", last_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
